axi_slv_ar_arbiter: RTL and testbench

//  Shares one AXI3 slave read port among NUM_MST masters, for the crossbar slave side.

---
 rtl/axi_slv_ar_arbiter_if.sv | 66 ++++++
 rtl/axi_slv_ar_arbiter.sv | 230 +++++++++++++++++++++++
 tb/tb_axi_slv_ar_arbiter.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_slv_ar_arbiter_if.sv
// ---------------------------------------------------------------------------
// axi_slv_ar_arbiter_if
//   Bundles the per-master AR/R channels and the shared AXI3 slave read port
//   handled by axi_slv_ar_arbiter.
//
//   Per-master side (packed, master i at [i*W +: W]):
//     m_arvalid/m_arready, m_araddr, m_arlen, m_arid   read address requests
//     m_rvalid/m_rready, m_rid, m_rdata, m_rresp, m_rlast   routed read data
//   Slave side:
//     s_arvalid/s_arready, s_araddr, s_arlen, s_arid   granted AR (ID widened by
//                                                      MST_IDX_W master-index MSBs)
//     s_rvalid/s_rready, s_rid, s_rdata, s_rresp, s_rlast   returning read data
//
//   Modports:
//     slave  - the arbiter's view (it sits on the slave side of the crossbar)
//     master - the surrounding environment: requesting masters + downstream slave
// ---------------------------------------------------------------------------
interface axi_slv_ar_arbiter_if #(
    parameter int NUM_MST    = 2,
    parameter int AXI_ADDR_W = 32,
    parameter int AXI_ID_W   = 4,
    parameter int AXI_DATA_W = 32
);
    localparam int MST_IDX_W = $clog2(NUM_MST);

    // master-side AR
    logic [NUM_MST-1:0]            m_arvalid;
    logic [NUM_MST-1:0]            m_arready;
    logic [NUM_MST*AXI_ADDR_W-1:0] m_araddr;
    logic [NUM_MST*4-1:0]          m_arlen;
    logic [NUM_MST*AXI_ID_W-1:0]   m_arid;
    // master-side R
    logic [NUM_MST-1:0]            m_rvalid;
    logic [NUM_MST-1:0]            m_rready;
    logic [AXI_ID_W-1:0]           m_rid;
    logic [AXI_DATA_W-1:0]         m_rdata;
    logic [1:0]                    m_rresp;
    logic                          m_rlast;
    // slave-side AR
    logic                          s_arvalid;
    logic                          s_arready;
    logic [AXI_ADDR_W-1:0]         s_araddr;
    logic [3:0]                    s_arlen;
    logic [AXI_ID_W+MST_IDX_W-1:0] s_arid;
    // slave-side R
    logic                          s_rvalid;
    logic                          s_rready;
    logic [AXI_ID_W+MST_IDX_W-1:0] s_rid;
    logic [AXI_DATA_W-1:0]         s_rdata;
    logic [1:0]                    s_rresp;
    logic                          s_rlast;

    modport slave (
        input  m_arvalid, m_araddr, m_arlen, m_arid, m_rready,
        output m_arready, m_rvalid, m_rid, m_rdata, m_rresp, m_rlast,
        output s_arvalid, s_araddr, s_arlen, s_arid, s_rready,
        input  s_arready, s_rvalid, s_rid, s_rdata, s_rresp, s_rlast
    );

    modport master (
        output m_arvalid, m_araddr, m_arlen, m_arid, m_rready,
        input  m_arready, m_rvalid, m_rid, m_rdata, m_rresp, m_rlast,
        input  s_arvalid, s_araddr, s_arlen, s_arid, s_rready,
        output s_arready, s_rvalid, s_rid, s_rdata, s_rresp, s_rlast
    );
endinterface

// File: rtl/axi_slv_ar_arbiter.sv
// ---------------------------------------------------------------------------
// axi_slv_ar_arbiter
//   Shares one AXI3 slave read port among NUM_MST masters. AR requests are
//   arbitrated round-robin; the winning master index is prepended to ARID so
//   returning R beats can be steered back by the ID MSBs. The number of read
//   bursts outstanding at the slave is tracked in ostd_cnt.
//
//   Ports:
//     aclk       clock
//     aresetn    asynchronous reset, active-low
//     srst       synchronous reset, active-high (same effect as aresetn)
//     bus        axi_slv_ar_arbiter_if.slave (all AR/R channel signals)
//     ostd_cnt   read bursts outstanding at the slave
//     route_err  sticky: R beat with invalid master index, or rlast underflow
//
//   Optional feature macro: AXI_ARB_OSTD_LIMIT_EN
//     defined   - no new grant is issued while ostd_cnt == SLV_OSTDREQ_NUM
//     undefined - arbitration never blocks; ostd_cnt saturates at the limit
// ---------------------------------------------------------------------------
module axi_slv_ar_arbiter #(
    parameter int NUM_MST         = 2,
    parameter int AXI_ADDR_W      = 32,
    parameter int AXI_ID_W        = 4,
    parameter int AXI_DATA_W      = 32,
    parameter int SLV_OSTDREQ_NUM = 4
) (
    input  logic                               aclk,
    input  logic                               aresetn,
    input  logic                               srst,
    axi_slv_ar_arbiter_if.slave                bus,
    output logic [$clog2(SLV_OSTDREQ_NUM):0]   ostd_cnt,
    output logic                               route_err
);
    localparam int MST_IDX_W = $clog2(NUM_MST);
    localparam int CNT_W     = $clog2(SLV_OSTDREQ_NUM) + 1;

    localparam logic [MST_IDX_W:0]   NUM_MST_EXT = (MST_IDX_W+1)'(NUM_MST);
    localparam logic [MST_IDX_W-1:0] LAST_MST    = MST_IDX_W'(NUM_MST - 1);
    localparam logic [CNT_W-1:0]     CNT_MAX     = CNT_W'(SLV_OSTDREQ_NUM);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [MST_IDX_W-1:0] grant_q, grant_d;
    logic [MST_IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]     ostd_cnt_q, ostd_cnt_d;
    logic                 route_err_q, route_err_d;

    // -----------------------------------------------------------------------
    // Unpack the per-master AR fields so the grant mux is a plain array index.
    // -----------------------------------------------------------------------
    logic [AXI_ADDR_W-1:0] mst_addr [NUM_MST];
    logic [3:0]            mst_len  [NUM_MST];
    logic [AXI_ID_W-1:0]   mst_id   [NUM_MST];

    for (genvar gi = 0; gi < NUM_MST; gi++) begin : g_unpack
        assign mst_addr[gi] = bus.m_araddr[gi*AXI_ADDR_W +: AXI_ADDR_W];
        assign mst_len[gi]  = bus.m_arlen[gi*4 +: 4];
        assign mst_id[gi]   = bus.m_arid[gi*AXI_ID_W +: AXI_ID_W];
    end

    // -----------------------------------------------------------------------
    // Round-robin candidate list: slot gi holds master (rr_ptr + gi) mod N.
    // The lowest occupied slot wins, i.e. the first requester at or after
    // rr_ptr.
    // -----------------------------------------------------------------------
    logic [MST_IDX_W-1:0] cand_idx [NUM_MST];
    logic [NUM_MST-1:0]   cand_req;

    for (genvar gi = 0; gi < NUM_MST; gi++) begin : g_cand
        logic [MST_IDX_W:0] sum;
        assign sum          = {1'b0, rr_ptr_q} + (MST_IDX_W+1)'(gi);
        assign cand_idx[gi] = (sum >= NUM_MST_EXT) ? MST_IDX_W'(sum - NUM_MST_EXT)
                                                   : sum[MST_IDX_W-1:0];
        assign cand_req[gi] = bus.m_arvalid[cand_idx[gi]];
    end

    logic                 pick_found;
    logic [MST_IDX_W-1:0] pick_idx;

    always_comb begin
        pick_found = |cand_req;
        pick_idx   = '0;
        for (int k = NUM_MST - 1; k >= 0; k--) begin
            if (cand_req[k]) begin
                pick_idx = cand_idx[k];
            end
        end
    end

    // -----------------------------------------------------------------------
    // Outstanding-limit gate
    // -----------------------------------------------------------------------
    logic cnt_full;
    logic cnt_zero;
    logic arb_block;

    assign cnt_full = (ostd_cnt_q == CNT_MAX);
    assign cnt_zero = (ostd_cnt_q == '0);

`ifdef AXI_ARB_OSTD_LIMIT_EN
    assign arb_block = cnt_full;
`else
    assign arb_block = 1'b0;
`endif

    // -----------------------------------------------------------------------
    // R routing: the ID MSBs carry the master index stamped on the AR.
    // Beats for an out-of-range index are accepted and dropped.
    // -----------------------------------------------------------------------
    logic [MST_IDX_W-1:0] r_idx;
    logic                 r_idx_ok;
    logic [NUM_MST-1:0]   r_sel;
    logic                 s_rready_c;

    assign r_idx    = bus.s_rid[AXI_ID_W +: MST_IDX_W];
    assign r_idx_ok = ({1'b0, r_idx} < NUM_MST_EXT);

    for (genvar gi = 0; gi < NUM_MST; gi++) begin : g_rsel
        assign r_sel[gi] = r_idx_ok && (r_idx == MST_IDX_W'(gi));
    end

    assign s_rready_c   = r_idx_ok ? |(r_sel & bus.m_rready) : 1'b1;
    assign bus.s_rready = s_rready_c;
    assign bus.m_rvalid = r_sel & {NUM_MST{bus.s_rvalid}};
    assign bus.m_rid    = bus.s_rid[AXI_ID_W-1:0];
    assign bus.m_rdata  = bus.s_rdata;
    assign bus.m_rresp  = bus.s_rresp;
    assign bus.m_rlast  = bus.s_rlast;

    // -----------------------------------------------------------------------
    // AR output mux and per-master ready
    // -----------------------------------------------------------------------
    logic               in_grant;
    logic               ar_hs;
    logic               r_last_hs;
    logic [NUM_MST-1:0] m_arready_c;

    assign in_grant  = (state_q == ST_GRANT);
    assign ar_hs     = in_grant && bus.s_arready;
    assign r_last_hs = bus.s_rvalid && s_rready_c && bus.s_rlast;

    for (genvar gi = 0; gi < NUM_MST; gi++) begin : g_arready
        assign m_arready_c[gi] = ar_hs && (grant_q == MST_IDX_W'(gi));
    end

    assign bus.m_arready = m_arready_c;
    assign bus.s_arvalid = in_grant;
    assign bus.s_araddr  = mst_addr[grant_q];
    assign bus.s_arlen   = mst_len[grant_q];
    assign bus.s_arid    = {grant_q, mst_id[grant_q]};

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;

        unique case (state_q)
            ST_IDLE: begin
                if (pick_found && !arb_block) begin
                    grant_d = pick_idx;
                    state_d = ST_GRANT;
                end
            end
            ST_GRANT: begin
                // Grant is held until the slave accepts; no preemption.
                if (bus.s_arready) begin
                    rr_ptr_d = (grant_q == LAST_MST) ? '0 : grant_q + 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        ostd_cnt_d = ostd_cnt_q;
        // Simultaneous issue and completion leaves the count unchanged.
        if (ar_hs && !r_last_hs) begin
            if (!cnt_full) begin
                ostd_cnt_d = ostd_cnt_q + 1'b1;
            end
        end else if (!ar_hs && r_last_hs) begin
            if (!cnt_zero) begin
                ostd_cnt_d = ostd_cnt_q - 1'b1;
            end
        end

        route_err_d = route_err_q
                    | (bus.s_rvalid && !r_idx_ok)
                    | (r_last_hs && cnt_zero);
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q     <= ST_IDLE;
            grant_q     <= '0;
            rr_ptr_q    <= '0;
            ostd_cnt_q  <= '0;
            route_err_q <= 1'b0;
        end else if (srst) begin
            state_q     <= ST_IDLE;
            grant_q     <= '0;
            rr_ptr_q    <= '0;
            ostd_cnt_q  <= '0;
            route_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            rr_ptr_q    <= rr_ptr_d;
            ostd_cnt_q  <= ostd_cnt_d;
            route_err_q <= route_err_d;
        end
    end

    assign ostd_cnt  = ostd_cnt_q;
    assign route_err = route_err_q;

endmodule

// File: tb/tb_axi_slv_ar_arbiter.sv
module tb_axi_slv_ar_arbiter;
    localparam int NUM_MST         = 2;
    localparam int AXI_ADDR_W      = 32;
    localparam int AXI_ID_W        = 4;
    localparam int AXI_DATA_W      = 32;
    localparam int SLV_OSTDREQ_NUM = 4;
    localparam int CNT_W           = $clog2(SLV_OSTDREQ_NUM) + 1;

    logic             aclk    = 1'b0;
    logic             aresetn = 1'b0;
    logic             srst    = 1'b0;
    logic [CNT_W-1:0] ostd_cnt;
    logic             route_err;

    int n_vec = 0;
    int n_err = 0;

    axi_slv_ar_arbiter_if #(
        .NUM_MST   (NUM_MST),
        .AXI_ADDR_W(AXI_ADDR_W),
        .AXI_ID_W  (AXI_ID_W),
        .AXI_DATA_W(AXI_DATA_W)
    ) bus_if ();

    axi_slv_ar_arbiter #(
        .NUM_MST        (NUM_MST),
        .AXI_ADDR_W     (AXI_ADDR_W),
        .AXI_ID_W       (AXI_ID_W),
        .AXI_DATA_W     (AXI_DATA_W),
        .SLV_OSTDREQ_NUM(SLV_OSTDREQ_NUM)
    ) dut (
        .aclk     (aclk),
        .aresetn  (aresetn),
        .srst     (srst),
        .bus      (bus_if),
        .ostd_cnt (ostd_cnt),
        .route_err(route_err)
    );

    always #5 aclk = ~aclk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic nedge();
        @(negedge aclk);
    endtask

    initial begin
        // Master 0: addr 0x1000 len 0 id 3; master 1: addr 0x2000 len 3 id 5
        bus_if.m_arvalid = '0;
        bus_if.m_araddr  = {32'h0000_2000, 32'h0000_1000};
        bus_if.m_arlen   = {4'd3, 4'd0};
        bus_if.m_arid    = {4'd5, 4'd3};
        bus_if.m_rready  = '0;
        bus_if.s_arready = 1'b0;
        bus_if.s_rvalid  = 1'b0;
        bus_if.s_rid     = '0;
        bus_if.s_rdata   = '0;
        bus_if.s_rresp   = 2'b00;
        bus_if.s_rlast   = 1'b0;

        // ---------------- reset state ----------------
        nedge(); nedge();
        chk("rst_s_arvalid", 64'(bus_if.s_arvalid), 64'h0);
        chk("rst_m_arready", 64'(bus_if.m_arready), 64'h0);
        chk("rst_ostd_cnt",  64'(ostd_cnt),         64'h0);
        chk("rst_route_err", 64'(route_err),        64'h0);
        chk("rst_m_rvalid",  64'(bus_if.m_rvalid),  64'h0);

        // ---------------- round-robin, both requesting ----------------
        aresetn          = 1'b1;
        bus_if.m_arvalid = 2'b11;
        bus_if.s_arready = 1'b1;
        nedge(); // grant M0
        chk("rr1_s_arvalid", 64'(bus_if.s_arvalid), 64'h1);
        chk("rr1_s_arid",    64'(bus_if.s_arid),    64'h03);
        chk("rr1_s_araddr",  64'(bus_if.s_araddr),  64'h1000);
        chk("rr1_s_arlen",   64'(bus_if.s_arlen),   64'h0);
        chk("rr1_m_arready", 64'(bus_if.m_arready), 64'h1);
        nedge();
        chk("rr1_idle",      64'(bus_if.s_arvalid), 64'h0);
        chk("rr1_ostd",      64'(ostd_cnt),         64'h1);
        nedge(); // grant M1
        chk("rr2_s_arid",    64'(bus_if.s_arid),    64'h15);
        chk("rr2_s_araddr",  64'(bus_if.s_araddr),  64'h2000);
        chk("rr2_s_arlen",   64'(bus_if.s_arlen),   64'h3);
        chk("rr2_m_arready", 64'(bus_if.m_arready), 64'h2);
        nedge();
        chk("rr2_ostd",      64'(ostd_cnt),         64'h2);
        nedge();
        chk("rr3_s_arid",    64'(bus_if.s_arid),    64'h03);
        nedge();
        chk("rr3_ostd",      64'(ostd_cnt),         64'h3);
        nedge();
        chk("rr4_s_arid",    64'(bus_if.s_arid),    64'h15);
        nedge();
        chk("rr4_ostd",      64'(ostd_cnt),         64'h4);
        chk("rr4_idle",      64'(bus_if.s_arvalid), 64'h0);
        bus_if.m_arvalid = 2'b00;

        // ---------------- 4-beat burst back to M1 ----------------
        bus_if.s_rvalid = 1'b1;
        bus_if.s_rid    = 6'h15;
        bus_if.m_rready = 2'b11;
        for (int b = 0; b < 4; b++) begin
            bus_if.s_rdata = 32'hA0 + 32'(b);
            bus_if.s_rlast = (b == 3);
            #1;
            chk("burst_m_rvalid", 64'(bus_if.m_rvalid), 64'h2);
            chk("burst_m_rid",    64'(bus_if.m_rid),    64'h5);
            chk("burst_m_rdata",  64'(bus_if.m_rdata),  64'hA0 + 64'(b));
            chk("burst_m_rlast",  64'(bus_if.m_rlast),  (b == 3) ? 64'h1 : 64'h0);
            chk("burst_s_rready", 64'(bus_if.s_rready), 64'h1);
            nedge();
        end
        chk("burst_ostd", 64'(ostd_cnt), 64'h3);
        bus_if.s_rid   = 6'h03;
        bus_if.s_rlast = 1'b1;
        #1;
        chk("r_m0_m_rvalid", 64'(bus_if.m_rvalid), 64'h1);
        chk("r_m0_m_rid",    64'(bus_if.m_rid),    64'h3);
        nedge();
        chk("r_m0_ostd",     64'(ostd_cnt),        64'h2);
        bus_if.s_rid    = 6'h15;
        bus_if.m_rready = 2'b01;    // M1 stalls its R channel
        #1;
        chk("r_bp_s_rready", 64'(bus_if.s_rready), 64'h0);
        chk("r_bp_m_rvalid", 64'(bus_if.m_rvalid), 64'h2);
        nedge();
        chk("r_bp_ostd",     64'(ostd_cnt),        64'h2);
        bus_if.m_rready = 2'b11;
        nedge();
        chk("r_m1_ostd",     64'(ostd_cnt),        64'h1);
        bus_if.s_rid = 6'h03;
        nedge();
        chk("r_drain_ostd",  64'(ostd_cnt),        64'h0);
        chk("r_drain_err",   64'(route_err),       64'h0);
        bus_if.s_rvalid = 1'b0;
        bus_if.s_rlast  = 1'b0;

        // ---------------- slave stall in GRANT, no preemption ----------------
        bus_if.m_arvalid = 2'b10;
        bus_if.s_arready = 1'b0;
        nedge();
        for (int c = 0; c < 10; c++) begin
            chk("stall_s_arvalid", 64'(bus_if.s_arvalid), 64'h1);
            chk("stall_s_araddr",  64'(bus_if.s_araddr),  64'h2000);
            chk("stall_s_arid",    64'(bus_if.s_arid),    64'h15);
            chk("stall_m_arready", 64'(bus_if.m_arready), 64'h0);
            if (c == 1) bus_if.m_arvalid = 2'b11;
            nedge();
        end
        bus_if.s_arready = 1'b1;
        #1;
        chk("stall_release_m_arready", 64'(bus_if.m_arready), 64'h2);
        nedge();
        chk("stall_done_idle", 64'(bus_if.s_arvalid), 64'h0);
        chk("stall_done_ostd", 64'(ostd_cnt),         64'h1);
        bus_if.s_arready = 1'b0;
        nedge();
        chk("pre_rst_g0_arid", 64'(bus_if.s_arid),    64'h03);
        bus_if.s_arready = 1'b1;
        nedge();
        chk("pre_rst_ostd",    64'(ostd_cnt),         64'h2);
        bus_if.s_arready = 1'b0;
        nedge();
        chk("pre_rst_g1_arid", 64'(bus_if.s_arid),    64'h15);

        // ---------------- async reset mid-GRANT ----------------
        aresetn = 1'b0;
        #1;
        chk("arst_s_arvalid", 64'(bus_if.s_arvalid), 64'h0);
        chk("arst_ostd",      64'(ostd_cnt),         64'h0);
        chk("arst_m_arready", 64'(bus_if.m_arready), 64'h0);
        nedge();
        aresetn          = 1'b1;
        bus_if.s_arready = 1'b1;
        nedge();
        // rr_ptr was 1 before reset; after reset M0 must win again
        chk("arst_rr_s_arid", 64'(bus_if.s_arid),    64'h03);
        nedge();
        chk("arst_rr_ostd",   64'(ostd_cnt),         64'h1);
        bus_if.m_arvalid = 2'b00;
        srst             = 1'b1;
        nedge();
        chk("srst_ostd",      64'(ostd_cnt),         64'h0);
        chk("srst_s_arvalid", 64'(bus_if.s_arvalid), 64'h0);
        srst = 1'b0;

        // ---------------- rlast underflow ----------------
        bus_if.s_rvalid = 1'b1;
        bus_if.s_rid    = 6'h03;
        bus_if.s_rlast  = 1'b1;
        nedge();
        chk("uflow_route_err", 64'(route_err), 64'h1);
        chk("uflow_ostd",      64'(ostd_cnt),  64'h0);
        bus_if.s_rvalid = 1'b0;
        bus_if.s_rlast  = 1'b0;
        nedge();
        chk("uflow_sticky",    64'(route_err), 64'h1);
        chk("uflow_ostd_hold", 64'(ostd_cnt),  64'h0);
        srst = 1'b1;
        nedge();
        srst = 1'b0;
        chk("srst_route_err",  64'(route_err), 64'h0);

        // ---------------- outstanding limit / saturation ----------------
        bus_if.m_arvalid = 2'b11;
        bus_if.s_arready = 1'b1;
        repeat (9) nedge();
`ifdef AXI_ARB_OSTD_LIMIT_EN
        chk("lim_5th_blocked", 64'(bus_if.s_arvalid), 64'h0);
        nedge();
        chk("lim_ostd_full",   64'(ostd_cnt),         64'h4);
        chk("lim_still_block", 64'(bus_if.s_arvalid), 64'h0);
        bus_if.s_rvalid = 1'b1;
        bus_if.s_rid    = 6'h03;
        bus_if.s_rlast  = 1'b1;
        nedge();
        bus_if.s_rvalid = 1'b0;
        bus_if.s_rlast  = 1'b0;
        chk("lim_ostd_drop",   64'(ostd_cnt),         64'h3);
        chk("lim_wait_1cyc",   64'(bus_if.s_arvalid), 64'h0);
        nedge();
        chk("lim_resume",      64'(bus_if.s_arvalid), 64'h1);
`else
        chk("sat_5th_granted", 64'(bus_if.s_arvalid), 64'h1);
        nedge();
        chk("sat_ostd_full",   64'(ostd_cnt),         64'h4);
        bus_if.m_arvalid = 2'b00;
        bus_if.s_rvalid  = 1'b1;
        bus_if.s_rid     = 6'h03;
        bus_if.s_rlast   = 1'b1;
        nedge();
        bus_if.s_rvalid = 1'b0;
        bus_if.s_rlast  = 1'b0;
        chk("sat_ostd_drop",   64'(ostd_cnt),         64'h3);
        nedge();
        chk("sat_no_req_idle", 64'(bus_if.s_arvalid), 64'h0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
